// File: rtl/stream_frame_checker.sv
// ============================================================================
// Module   : stream_frame_checker
// Brief    : AXI4-Stream video sink that checks SOF/EOL framing against the
//            configured dimensions and publishes registered frame statistics.
//            Optional feature macro: FRAME_CHECKSUM_EN (per-frame checksum).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_frame_checker #(
  parameter int BEATS_PER_LINE = 480,
  parameter int LINES          = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  input  logic        sink_en,
  input  logic        clr_err,
  output logic        frame_done,
  output logic [31:0] frame_checksum,
  output logic [15:0] frame_count,
  output logic [2:0]  err_flags,
  output logic [15:0] err_count
);

  localparam int BX_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int LY_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [BX_W-1:0] BX_LAST = BX_W'(BEATS_PER_LINE - 1);
  localparam logic [LY_W-1:0] LY_LAST = LY_W'(LINES - 1);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [BX_W-1:0] bx_q, bx_d, cur_bx;
  logic [LY_W-1:0] ly_q, ly_d, cur_ly;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [2:0]      err_flags_q, err_flags_d;
  logic [15:0]     err_count_q, err_count_d;

  logic       accept, origin, run, restart, advance;
  logic       line_end, frame_end, complete;
  logic [2:0] err_evt;
  logic       unused_tkeep;

  assign in_stream_tready = sink_en;
  assign accept           = in_stream_tvalid & sink_en;
  assign origin           = (bx_q == '0) && (ly_q == '0);
  assign unused_tkeep     = ^in_stream_tkeep;

  always_comb begin
    state_d       = state_q;
    bx_d          = bx_q;
    ly_d          = ly_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_flags_d   = err_flags_q;
    err_count_d   = err_count_q;
    err_evt       = 3'b000;
    run           = 1'b0;
    restart       = 1'b0;
    complete      = 1'b0;
    cur_bx        = bx_q;
    cur_ly        = ly_q;

    // A beat taken as (0,0) (SOF in HUNT or a restart) is evaluated at origin.
    if (accept) begin
      if (state_q == ST_HUNT) begin
        if (in_stream_tuser) begin
          run    = 1'b1;
          cur_bx = '0;
          cur_ly = '0;
        end
      end else if (in_stream_tuser && !origin) begin
        err_evt = 3'b001;
        restart = 1'b1;
        cur_bx  = '0;
        cur_ly  = '0;
      end else if (!in_stream_tuser && origin) begin
        err_evt = 3'b001;
      end else begin
        run = 1'b1;
      end
    end

    line_end  = (cur_bx == BX_LAST);
    frame_end = line_end && (cur_ly == LY_LAST);

    if (run) begin
      if (in_stream_tlast && !line_end) begin
        err_evt = 3'b010;
      end else if (!in_stream_tlast && line_end) begin
        err_evt = 3'b100;
      end
    end

    advance = (run && (err_evt == 3'b000)) || restart;

    if (advance) begin
      state_d = ST_RECV;
      bx_d    = line_end ? '0 : cur_bx + 1'b1;
      ly_d    = frame_end ? '0 : (line_end ? cur_ly + 1'b1 : cur_ly);
      if (run && frame_end) begin
        complete      = 1'b1;
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
      end
    end else if (err_evt != 3'b000) begin
      state_d = ST_HUNT;
      bx_d    = '0;
      ly_d    = '0;
    end

    // A new error outranks a coincident clear.
    if (err_evt != 3'b000) begin
      err_flags_d = (clr_err ? 3'b000 : err_flags_q) | err_evt;
      if (clr_err) begin
        err_count_d = 16'd1;
      end else if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
    end else if (clr_err) begin
      err_flags_d = 3'b000;
      err_count_d = 16'd0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_HUNT;
      bx_q          <= '0;
      ly_q          <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      err_flags_q   <= 3'b000;
      err_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      bx_q          <= bx_d;
      ly_q          <= ly_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_flags_q   <= err_flags_d;
      err_count_q   <= err_count_d;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] frame_checksum_q, frame_checksum_d;

  always_comb begin
    acc_d            = acc_q;
    frame_checksum_d = frame_checksum_q;
    if (advance) begin
      if (restart || ((cur_bx == '0) && (cur_ly == '0))) begin
        acc_d = in_stream_tdata;
      end else begin
        acc_d = {acc_q[30:0], acc_q[31]} ^ in_stream_tdata;
      end
    end
    if (complete) begin
      frame_checksum_d = acc_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q            <= 32'h0;
      frame_checksum_q <= 32'h0;
    end else begin
      acc_q            <= acc_d;
      frame_checksum_q <= frame_checksum_d;
    end
  end

  assign frame_checksum = frame_checksum_q;
`else
  logic unused_cksum;
  assign unused_cksum   = ^in_stream_tdata ^ complete;
  assign frame_checksum = 32'h0;
`endif

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_flags   = err_flags_q;
  assign err_count   = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_frame_checker.sv
// Directed self-checking bench for stream_frame_checker (4 beats x 3 lines).
`default_nettype none

module tb_stream_frame_checker;

  localparam int BPL = 4;
  localparam int NL  = 3;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [31:0] EXP_CK = 32'h00000FFF;
`else
  localparam logic [31:0] EXP_CK = 32'h00000000;
`endif

  logic        aclk;
  logic        aresetn;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic        sink_en, clr_err;
  logic        frame_done;
  logic [31:0] frame_checksum;
  logic [15:0] frame_count;
  logic [2:0]  err_flags;
  logic [15:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  stream_frame_checker #(
    .BEATS_PER_LINE(BPL),
    .LINES         (NL)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .in_stream_tdata (tdata),
    .in_stream_tkeep (tkeep),
    .in_stream_tlast (tlast),
    .in_stream_tuser (tuser),
    .in_stream_tvalid(tvalid),
    .in_stream_tready(tready),
    .sink_en         (sink_en),
    .clr_err         (clr_err),
    .frame_done      (frame_done),
    .frame_checksum  (frame_checksum),
    .frame_count     (frame_count),
    .err_flags       (err_flags),
    .err_count       (err_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic do_reset();
    aresetn = 1'b0;
    tvalid  = 1'b0;
    tuser   = 1'b0;
    tlast   = 1'b0;
    tdata   = 32'h0;
    sink_en = 1'b1;
    clr_err = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // One beat, accepted on the next rising edge; returns at edge + 1.
  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tvalid = 1'b1;
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < BPL * NL; i++) send_beat(32'h1, i == 0, (i % BPL) == BPL - 1);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    sink_en = 1'b0;
    tvalid  = 1'b0;
    tuser   = 1'b0;
    tlast   = 1'b0;
    tdata   = 32'h0;
    clr_err = 1'b0;
    #1;
    n_cmp++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready_lo: got %b expected 0", tready); end
    sink_en = 1'b1;
    #1;
    n_cmp++; if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready_hi: got %b expected 1", tready); end
    @(posedge aclk); #1;
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    n_cmp++; if (frame_checksum !== 32'h0) begin n_fail++; $display("FAIL reset_ck: got %h expected 0", frame_checksum); end
    n_cmp++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
    n_cmp++; if (err_flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", err_flags); end
    n_cmp++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", err_count); end
    aresetn = 1'b1;
  endtask

  task automatic test_clean_frame();
    do_reset();
    for (int i = 0; i < BPL * NL - 1; i++) send_beat(32'h1, i == 0, (i % BPL) == BPL - 1);
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL clean_early_done: got %b expected 0", frame_done); end
    send_beat(32'h1, 1'b0, 1'b1);
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %b expected 1", frame_done); end
    n_cmp++; if (frame_checksum !== EXP_CK) begin n_fail++; $display("FAIL clean_ck: got %h expected %h", frame_checksum, EXP_CK); end
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL clean_count: got %0d expected 1", frame_count); end
    n_cmp++; if (err_flags !== 3'b000) begin n_fail++; $display("FAIL clean_flags: got %b expected 000", err_flags); end
    @(posedge aclk); #1;
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL clean_done_pulse: got %b expected 0", frame_done); end
    n_cmp++; if (frame_checksum !== EXP_CK) begin n_fail++; $display("FAIL clean_ck_hold: got %h expected %h", frame_checksum, EXP_CK); end
  endtask

  task automatic test_backpressure();
    int acc_beats;
    int cyc;
    do_reset();
    acc_beats = 0;
    cyc       = 0;
    while (acc_beats < BPL * NL && cyc < 400) begin
      tdata   = 32'h1;
      tuser   = (acc_beats == 0);
      tlast   = ((acc_beats % BPL) == BPL - 1);
      tvalid  = ($urandom_range(0, 3) != 0);
      sink_en = cyc[0];
      #1;
      n_cmp++; if (tready !== sink_en) begin n_fail++; $display("FAIL bp_tready: got %b expected %b", tready, sink_en); end
      if (tvalid && sink_en) acc_beats++;
      @(posedge aclk); #1;
      if (acc_beats < BPL * NL) begin
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL bp_premature_done: got %b expected 0 after %0d beats", frame_done, acc_beats); end
      end
      cyc++;
    end
    tvalid  = 1'b0;
    tuser   = 1'b0;
    tlast   = 1'b0;
    sink_en = 1'b1;
    n_cmp++; if (cyc >= 400) begin n_fail++; $display("FAIL bp_timeout: got %0d beats expected %0d", acc_beats, BPL * NL); end
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1", frame_done); end
    n_cmp++; if (frame_checksum !== EXP_CK) begin n_fail++; $display("FAIL bp_ck: got %h expected %h", frame_checksum, EXP_CK); end
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL bp_count: got %0d expected 1", frame_count); end
  endtask

  task automatic test_eol_errors();
    do_reset();
    send_beat(32'h1, 1'b1, 1'b0);
    send_beat(32'h1, 1'b0, 1'b0);
    send_beat(32'h1, 1'b0, 1'b1);
    n_cmp++; if (err_flags !== 3'b010) begin n_fail++; $display("FAIL eol_early_flags: got %b expected 010", err_flags); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL eol_early_cnt: got %0d expected 1", err_count); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL eol_early_done: got %b expected 0", frame_done); end
    send_beat(32'h5, 1'b0, 1'b0);
    send_beat(32'h5, 1'b0, 1'b1);
    send_frame();
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL eol_recover_count: got %0d expected 1", frame_count); end
    n_cmp++; if (frame_checksum !== EXP_CK) begin n_fail++; $display("FAIL eol_recover_ck: got %h expected %h", frame_checksum, EXP_CK); end
    n_cmp++; if (err_flags !== 3'b010) begin n_fail++; $display("FAIL eol_recover_flags: got %b expected 010", err_flags); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL eol_recover_cnt: got %0d expected 1", err_count); end
    // Late EOL coinciding with clr_err: only the new error remains.
    send_beat(32'h1, 1'b1, 1'b0);
    send_beat(32'h1, 1'b0, 1'b0);
    send_beat(32'h1, 1'b0, 1'b0);
    clr_err = 1'b1;
    send_beat(32'h1, 1'b0, 1'b0);
    clr_err = 1'b0;
    n_cmp++; if (err_flags !== 3'b100) begin n_fail++; $display("FAIL eol_late_clr_flags: got %b expected 100", err_flags); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL eol_late_clr_cnt: got %0d expected 1", err_count); end
    clr_err = 1'b1;
    @(posedge aclk); #1;
    clr_err = 1'b0;
    n_cmp++; if (err_flags !== 3'b000) begin n_fail++; $display("FAIL clr_flags: got %b expected 000", err_flags); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", err_count); end
  endtask

  task automatic test_sof_errors();
    do_reset();
    for (int i = 0; i < 5; i++) send_beat(32'h1, i == 0, (i % BPL) == BPL - 1);
    for (int j = 0; j < BPL * NL; j++) begin
      send_beat(32'h1, j == 0, (j % BPL) == BPL - 1);
      if (j == 0) begin
        n_cmp++; if (err_flags !== 3'b001) begin n_fail++; $display("FAIL sof_mid_flags: got %b expected 001", err_flags); end
        n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL sof_mid_cnt: got %0d expected 1", err_count); end
      end
    end
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL sof_restart_done: got %b expected 1", frame_done); end
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL sof_restart_count: got %0d expected 1", frame_count); end
    n_cmp++; if (frame_checksum !== EXP_CK) begin n_fail++; $display("FAIL sof_restart_ck: got %h expected %h", frame_checksum, EXP_CK); end
    // Missing SOF on the first beat after a completed frame.
    send_beat(32'h1, 1'b0, 1'b0);
    n_cmp++; if (err_flags !== 3'b001) begin n_fail++; $display("FAIL sof_missing_flags: got %b expected 001", err_flags); end
    n_cmp++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL sof_missing_cnt: got %0d expected 2", err_count); end
    send_frame();
    n_cmp++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL sof_after_count: got %0d expected 2", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame();
    send_beat(32'h1, 1'b1, 1'b0);
    send_beat(32'h1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send_beat(32'h1, i == 0, (i % BPL) == BPL - 1);
    #1 aresetn = 1'b0;
    #1;
    n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", frame_count); end
    n_cmp++; if (frame_checksum !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ck: got %h expected 0", frame_checksum); end
    n_cmp++; if (err_flags !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", err_flags); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d expected 0", err_count); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    send_beat(32'h7, 1'b0, 1'b0);
    send_frame();
    n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 1", frame_count); end
    n_cmp++; if (frame_checksum !== EXP_CK) begin n_fail++; $display("FAIL rst_after_ck: got %h expected %h", frame_checksum, EXP_CK); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_after_cnt: got %0d expected 0", err_count); end
  endtask

  initial begin
    tkeep = 4'hF;
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_eol_errors();
    test_sof_errors();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
